riscv_ctrl_stage: RTL and testbench

Registered main-control unit for the RV32 pipeline: decodes the full 7-bit opcode (plus funct7 for M-ops) and drives the ID/EX control bundle directly from a flop stage.
- Adds stall hold, flush-to-bubble, illegal-opcode detection, JAL/JALR support and a multi-cycle MUL/DIV sequencer that back-pressures the front end.
- Sits between the IF/ID register and the EX stage, replacing the combinational decoder plus the control slice of ID/EX.

---
 rtl/riscv_ctrl_pkg.sv | 42 ++++
 rtl/riscv_ctrl_decode.sv | 78 +++++++
 rtl/riscv_ctrl_stage.sv | 134 +++++++++++++
 tb/tb_riscv_ctrl_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the registered RV32 main-control stage:
//   - major opcode constants and the funct7 value that marks an M-extension op
//   - ALUOp and write-back select encodings
//   - the ID/EX control bundle struct and its all-zero bubble value
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_RFN  = 2'b10;
    localparam logic [1:0] ALUOP_IFN  = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       muldiv;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// riscv_ctrl_decode
// Pure combinational main decoder: opcode/funct7 -> control bundle + illegal flag.
// Ports:
//   valid_i    in   IF/ID holds a real instruction (0 -> bubble, never illegal)
//   opcode_i   in   instruction[6:0]
//   funct7_i   in   instruction[31:25]
//   ctrl_o     out  decoded bundle (bubble for illegal or invalid)
//   illegal_o  out  opcode (or M-op with the extension absent) is unsupported
// Build option: CTRL_MULDIV_EN enables decoding of M-extension R-type ops.
module riscv_ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = BUBBLE;
        illegal_o = 1'b0;
        if (valid_i) begin
            ctrl_o.valid = 1'b1;
            case (opcode_i)
                OP_R: begin
                    ctrl_o.alu_op    = ALUOP_RFN;
                    ctrl_o.reg_write = 1'b1;
                    if (funct7_i == FUNCT7_MULDIV) begin
`ifdef CTRL_MULDIV_EN
                        ctrl_o.muldiv = 1'b1;
`else
                        ctrl_o    = BUBBLE;
                        illegal_o = 1'b1;
`endif
                    end
                end
                OP_IMM: begin
                    ctrl_o.alu_op    = ALUOP_IFN;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                OP_LOAD: begin
                    ctrl_o.alu_op     = ALUOP_ADD;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = WB_MEM;
                end
                OP_STORE: begin
                    ctrl_o.alu_op    = ALUOP_ADD;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl_o.alu_op = ALUOP_SUB;
                    ctrl_o.branch = 1'b1;
                end
                OP_JAL: begin
                    ctrl_o.jump       = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = WB_PC4;
                end
                OP_JALR: begin
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.jump       = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = WB_PC4;
                end
                default: begin
                    ctrl_o    = BUBBLE;
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_ctrl_stage.sv
// riscv_ctrl_stage
// Registered main-control stage between IF/ID and EX. Decodes the instruction and
// holds the ID/EX control bundle in flops, with stall hold, flush-to-bubble,
// illegal-opcode pulse and an optional multi-cycle MUL/DIV sequencer.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i, opcode_i,      instruction from IF/ID
//   funct7_i
//   stall_i, flush_i        hazard hold / branch squash (flush wins)
//   valid_o ... MemtoReg_o  registered control bundle
//   muldiv_o                bundle is an M-extension op
//   busy_o                  M-op still occupying EX; front end must stall
//   illegal_o               one-cycle pulse for an unsupported instruction
// Build option: CTRL_MULDIV_EN adds the IDLE/BUSY sequencer; without it busy_o
// and muldiv_o stay 0 and M-ops decode as illegal.
module riscv_ctrl_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    input  logic       stall_i,
    input  logic       flush_i,
    output logic       valid_o,
    output logic [1:0] ALUOp_o,
    output logic       ALUSrc_o,
    output logic       branch_o,
    output logic       jump_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       RegWrite_o,
    output logic [1:0] MemtoReg_o,
    output logic       muldiv_o,
    output logic       busy_o,
    output logic       illegal_o
);

    if (MULDIV_LAT < 1 || MULDIV_LAT > 16) begin : g_bad_lat
        $error("MULDIV_LAT out of range 1..16");
    end
    if ((2 ** CNT_W) <= (MULDIV_LAT - 1)) begin : g_bad_cnt
        $error("CNT_W too narrow for MULDIV_LAT");
    end

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    ctrl_t ctrl_q;
    logic  illegal_q;
    logic  busy;

    riscv_ctrl_decode u_decode (
        .valid_i   (valid_i),
        .opcode_i  (opcode_i),
        .funct7_i  (funct7_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

`ifdef CTRL_MULDIV_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= BUBBLE;
            illegal_q <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
        end else if (flush_i) begin
            // Aborting a busy op here means its masked RegWrite never surfaces.
            ctrl_q    <= BUBBLE;
            illegal_q <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
        end else if (stall_i) begin
            illegal_q <= 1'b0;
        end else if (state_q == ST_BUSY) begin
            illegal_q <= 1'b0;
            cnt_q     <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_q <= ST_IDLE;
            end
        end else begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            if (dec_ctrl.muldiv && (MULDIV_LAT > 1)) begin
                state_q <= ST_BUSY;
                cnt_q   <= CNT_LOAD;
            end
        end
    end

    assign busy = (state_q == ST_BUSY);
`else
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ctrl_q    <= BUBBLE;
            illegal_q <= 1'b0;
        end else if (stall_i) begin
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
        end
    end

    assign busy = 1'b0;
`endif

    assign valid_o    = ctrl_q.valid;
    assign ALUOp_o    = ctrl_q.alu_op;
    assign ALUSrc_o   = ctrl_q.alu_src;
    assign branch_o   = ctrl_q.branch;
    assign jump_o     = ctrl_q.jump;
    assign MemRead_o  = ctrl_q.mem_read;
    assign MemWrite_o = ctrl_q.mem_write;
    // Write-back only once the multi-cycle result is complete.
    assign RegWrite_o = ctrl_q.reg_write & ~busy;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    // Decoder never sets muldiv without the extension, so this is 0 in that build.
    assign muldiv_o   = ctrl_q.muldiv;
    assign busy_o     = busy;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_riscv_ctrl_stage.sv
// Bench for riscv_ctrl_stage: directed vector table plus randomized run against a
// cycle-level reference model of the control-stage rules.
module tb_riscv_ctrl_stage;

    localparam int LAT = 4;

    // Observed/expected layout (MSB..LSB):
    // valid, ALUOp[1:0], ALUSrc, branch, jump, MemRead, MemWrite, RegWrite,
    // MemtoReg[1:0], muldiv, busy, illegal
    localparam logic [13:0] E_BUB  = 14'b0_00_0_0_0_0_0_0_00_0_0_0;
    localparam logic [13:0] E_LOAD = 14'b1_00_1_0_0_1_0_1_01_0_0_0;
    localparam logic [13:0] E_STOR = 14'b1_00_1_0_0_0_1_0_00_0_0_0;
    localparam logic [13:0] E_JAL  = 14'b1_00_0_0_1_0_0_1_10_0_0_0;
    localparam logic [13:0] E_JALR = 14'b1_00_1_0_1_0_0_1_10_0_0_0;
    localparam logic [13:0] E_R    = 14'b1_10_0_0_0_0_0_1_00_0_0_0;
    localparam logic [13:0] E_IMM  = 14'b1_11_1_0_0_0_0_1_00_0_0_0;
    localparam logic [13:0] E_BR   = 14'b1_01_0_1_0_0_0_0_00_0_0_0;
    localparam logic [13:0] E_ILL  = 14'b0_00_0_0_0_0_0_0_00_0_0_1;
    localparam logic [13:0] E_MULB = 14'b1_10_0_0_0_0_0_0_00_1_1_0;
    localparam logic [13:0] E_MULD = 14'b1_10_0_0_0_0_0_1_00_1_0_0;

    localparam logic [6:0] O_R = 7'b0110011, O_IMM = 7'b0010011, O_LD = 7'b0000011;
    localparam logic [6:0] O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_BAD = 7'b1111111;
    localparam logic [6:0] F_MD = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_i, valid_i, stall_i, flush_i;
    logic [6:0] opcode_i, funct7_i;
    logic       valid_o, ALUSrc_o, branch_o, jump_o, MemRead_o, MemWrite_o, RegWrite_o;
    logic       muldiv_o, busy_o, illegal_o;
    logic [1:0] ALUOp_o, MemtoReg_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_ctrl_stage #(
        .MULDIV_LAT (LAT),
        .CNT_W      (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .opcode_i   (opcode_i),
        .funct7_i   (funct7_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ALUOp_o    (ALUOp_o),
        .ALUSrc_o   (ALUSrc_o),
        .branch_o   (branch_o),
        .jump_o     (jump_o),
        .MemRead_o  (MemRead_o),
        .MemWrite_o (MemWrite_o),
        .RegWrite_o (RegWrite_o),
        .MemtoReg_o (MemtoReg_o),
        .muldiv_o   (muldiv_o),
        .busy_o     (busy_o),
        .illegal_o  (illegal_o)
    );

    function automatic logic [13:0] observed();
        return {valid_o, ALUOp_o, ALUSrc_o, branch_o, jump_o, MemRead_o, MemWrite_o,
                RegWrite_o, MemtoReg_o, muldiv_o, busy_o, illegal_o};
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = observed();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst, valid, stall, flush;
        logic [6:0]  op, f7;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic valid,
                       input logic [6:0] op, input logic [6:0] f7, input logic stall,
                       input logic flush, input logic [13:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.valid = valid; v.op = op; v.f7 = f7;
        v.stall = stall; v.flush = flush; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic valid, input logic [6:0] op,
                         input logic [6:0] f7, input logic stall, input logic flush);
        rst_i = rst; valid_i = valid; opcode_i = op; funct7_i = f7;
        stall_i = stall; flush_i = flush;
        @(posedge clk);
        #1;
    endtask

    // Reference model: spec rules with a remaining-busy-cycles integer.
    logic [13:0] m_ctrl;   // bundle with raw RegWrite, busy/illegal bits zero
    logic        m_ill;
    int          m_left;

    function automatic logic [14:0] ref_decode(input logic valid, input logic [6:0] op,
                                               input logic [6:0] f7);
        if (!valid) return {E_BUB, 1'b0};
        case (op)
            O_R: begin
                if (f7 == F_MD) begin
`ifdef CTRL_MULDIV_EN
                    return {E_MULD, 1'b0};
`else
                    return {E_BUB, 1'b1};
`endif
                end
                return {E_R, 1'b0};
            end
            O_IMM:   return {E_IMM, 1'b0};
            O_LD:    return {E_LOAD, 1'b0};
            O_ST:    return {E_STOR, 1'b0};
            O_BR:    return {E_BR, 1'b0};
            O_JAL:   return {E_JAL, 1'b0};
            O_JALR:  return {E_JALR, 1'b0};
            default: return {E_BUB, 1'b1};
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic valid, input logic [6:0] op,
                              input logic [6:0] f7, input logic stall, input logic flush);
        logic [14:0] d;
        if (rst || flush) begin
            m_ctrl = E_BUB; m_ill = 1'b0; m_left = 0;
        end else if (stall) begin
            m_ill = 1'b0;
        end else if (m_left > 0) begin
            m_left--; m_ill = 1'b0;
        end else begin
            d = ref_decode(valid, op, f7);
            m_ctrl = d[14:1];
            m_ill  = d[0];
            if (m_ctrl[2] && LAT > 1) m_left = LAT - 1;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [13:0] e;
        e = m_ctrl;
        e[1] = (m_left > 0);
        e[5] = m_ctrl[5] & (m_left == 0);
        e[0] = m_ill;
        return e;
    endfunction

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; opcode_i = '0; funct7_i = '0;
        stall_i = 1'b0; flush_i = 1'b0;

        add("reset0",        1, 0, 7'h0,  7'h0, 0, 0, E_BUB);
        add("reset1",        1, 0, 7'h0,  7'h0, 0, 0, E_BUB);
        add("load",          0, 1, O_LD,  7'h0, 0, 0, E_LOAD);
        add("store",         0, 1, O_ST,  7'h0, 0, 0, E_STOR);
        add("jal",           0, 1, O_JAL, 7'h0, 0, 0, E_JAL);
        add("load2",         0, 1, O_LD,  7'h0, 0, 0, E_LOAD);
        add("stall_hold1",   0, 1, O_R,   7'h0, 1, 0, E_LOAD);
        add("stall_hold2",   0, 1, O_R,   7'h0, 1, 0, E_LOAD);
        add("stall_hold3",   0, 1, O_R,   7'h0, 1, 0, E_LOAD);
        add("flush_over_stall", 0, 1, O_R, 7'h0, 1, 1, E_BUB);
        add("illegal",       0, 1, O_BAD, 7'h0, 0, 0, E_ILL);
        add("illegal_clear", 0, 1, O_R,   7'h20, 0, 0, E_R);
        add("illegal_again", 0, 1, 7'h00, 7'h0, 0, 0, E_ILL);
        add("illegal_stall", 0, 1, O_LD,  7'h0, 1, 0, E_BUB);
        add("invalid_bubble",0, 0, O_BAD, 7'h0, 0, 0, E_BUB);
        add("jalr",          0, 1, O_JALR,7'h0, 0, 0, E_JALR);
        add("imm",           0, 1, O_IMM, 7'h0, 0, 0, E_IMM);
        add("branch",        0, 1, O_BR,  7'h0, 0, 0, E_BR);
        add("load3",         0, 1, O_LD,  7'h0, 0, 0, E_LOAD);
        add("mid_reset1",    1, 1, O_LD,  7'h0, 0, 0, E_BUB);
        add("mid_reset2",    1, 1, O_LD,  7'h0, 0, 0, E_BUB);
`ifdef CTRL_MULDIV_EN
        add("mul_busy1",     0, 1, O_R,   F_MD, 0, 0, E_MULB);
        add("mul_busy2",     0, 1, O_LD,  7'h0, 0, 0, E_MULB);
        add("mul_busy3",     0, 1, O_LD,  7'h0, 0, 0, E_MULB);
        add("mul_done",      0, 1, O_LD,  7'h0, 0, 0, E_MULD);
        add("after_mul",     0, 1, O_LD,  7'h0, 0, 0, E_LOAD);
        add("muls_busy1",    0, 1, O_R,   F_MD, 0, 0, E_MULB);
        add("muls_stall1",   0, 1, O_ST,  7'h0, 1, 0, E_MULB);
        add("muls_stall2",   0, 1, O_ST,  7'h0, 1, 0, E_MULB);
        add("muls_busy4",    0, 1, O_ST,  7'h0, 0, 0, E_MULB);
        add("muls_busy5",    0, 1, O_ST,  7'h0, 0, 0, E_MULB);
        add("muls_done",     0, 1, O_ST,  7'h0, 0, 0, E_MULD);
        add("after_muls",    0, 1, O_ST,  7'h0, 0, 0, E_STOR);
        add("mulf_busy1",    0, 1, O_R,   F_MD, 0, 0, E_MULB);
        add("mulf_busy2",    0, 1, O_JAL, 7'h0, 0, 0, E_MULB);
        add("mulf_flush",    0, 1, O_JAL, 7'h0, 0, 1, E_BUB);
        add("after_flush",   0, 1, O_JAL, 7'h0, 0, 0, E_JAL);
        add("mulr_busy1",    0, 1, O_R,   F_MD, 0, 0, E_MULB);
        add("mulr_reset",    1, 1, O_R,   F_MD, 0, 0, E_BUB);
        add("after_reset",   0, 1, O_IMM, 7'h0, 0, 0, E_IMM);
`else
        add("mul_illegal",   0, 1, O_R,   F_MD, 0, 0, E_ILL);
        add("mul_no_busy",   0, 1, O_LD,  7'h0, 0, 0, E_LOAD);
        add("mul_ill_again", 0, 1, O_R,   F_MD, 0, 0, E_ILL);
        add("mul_ill_clear", 0, 0, O_R,   F_MD, 0, 0, E_BUB);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].f7,
                  vecs[i].stall, vecs[i].flush);
            check(vecs[i].name, vecs[i].exp);
        end

        // Randomized run against the reference model, starting from reset.
        for (int c = 0; c < 600; c++) begin
            logic       r, v, s, f;
            logic [6:0] op, f7;
            logic [6:0] ops [9];
            ops = '{O_R, O_IMM, O_LD, O_ST, O_BR, O_JAL, O_JALR, O_BAD, 7'h00};
            r  = (c == 0) || ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 7) != 0);
            s  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 11) == 0);
            op = ops[$urandom_range(0, 8)];
            if (op == 7'h00) op = 7'($urandom);
            f7 = ($urandom_range(0, 2) == 0) ? F_MD : 7'($urandom);
            drive(r, v, op, f7, s, f);
            model_step(r, v, op, f7, s, f);
            check($sformatf("random_%0d", c), model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
